// File: rtl/gate_pair_apply.sv
// Streaming 2x2 complex gate stage: (b0, b1) = U * (a0, a1) on Q2.(IN_BITS-2)
// amplitudes, three-stage valid/ready pipeline with saturating sums.

module complex_fix_mul #(
  parameter int IN_BITS   = 19,
  parameter int PROD_BITS = IN_BITS + 1
) (
  input  logic [2*IN_BITS-1:0]   a_i,
  input  logic [2*IN_BITS-1:0]   b_i,
  output logic [2*PROD_BITS-1:0] p_o
);
  localparam int FW = 2*IN_BITS + 1;

  logic signed [IN_BITS-1:0] ar, ai, br, bi;
  logic signed [FW-1:0]      re_full, im_full, re_sh, im_sh;

  function automatic logic [PROD_BITS-1:0] sat_prod(input logic [FW-1:0] v);
    if ((&v[FW-1:PROD_BITS-1]) || !(|v[FW-1:PROD_BITS-1]))
      return v[PROD_BITS-1:0];
    else if (v[FW-1])
      return {1'b1, {(PROD_BITS-1){1'b0}}};
    else
      return {1'b0, {(PROD_BITS-1){1'b1}}};
  endfunction

  assign ar = a_i[IN_BITS-1:0];
  assign ai = a_i[2*IN_BITS-1:IN_BITS];
  assign br = b_i[IN_BITS-1:0];
  assign bi = b_i[2*IN_BITS-1:IN_BITS];

  // Exact full-width products, then a single floor shift back to Q2 scaling.
  assign re_full = FW'(ar) * FW'(br) - FW'(ai) * FW'(bi);
  assign im_full = FW'(ar) * FW'(bi) + FW'(ai) * FW'(br);
  assign re_sh   = re_full >>> (IN_BITS - 2);
  assign im_sh   = im_full >>> (IN_BITS - 2);

  assign p_o = {sat_prod(im_sh), sat_prod(re_sh)};
endmodule

module gate_pair_apply #(
  parameter int IN_BITS   = 19,
  parameter int PROD_BITS = IN_BITS + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gate_we,
  input  logic [1:0]           gate_sel,
  input  logic [2*IN_BITS-1:0] gate_coef,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*IN_BITS-1:0] in_a0,
  input  logic [2*IN_BITS-1:0] in_a1,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*IN_BITS-1:0] out_b0,
  output logic [2*IN_BITS-1:0] out_b1,
  output logic                 out_last,
  output logic                 sat_flag
);
  localparam int CW = 2*IN_BITS;
  localparam int PW = 2*PROD_BITS;
  localparam int SW = PROD_BITS + 1;
  localparam logic [CW-1:0] ONE = CW'(1) << (IN_BITS - 2);

  function automatic logic sum_ovf(input logic [SW-1:0] s);
    return !((&s[SW-1:IN_BITS-1]) || !(|s[SW-1:IN_BITS-1]));
  endfunction

  function automatic logic [IN_BITS-1:0] sat_sum(input logic [SW-1:0] s);
    if (!sum_ovf(s))
      return s[IN_BITS-1:0];
    else if (s[SW-1])
      return {1'b1, {(IN_BITS-1){1'b0}}};
    else
      return {1'b0, {(IN_BITS-1){1'b1}}};
  endfunction

  function automatic logic [SW-1:0] add_ext(input logic [PROD_BITS-1:0] x,
                                            input logic [PROD_BITS-1:0] y);
    return {x[PROD_BITS-1], x} + {y[PROD_BITS-1], y};
  endfunction

  logic          en, accept, wr_ok;
  logic          vld_p1_q, vld_p2_q, vld_p3_q;
  logic          last_p1_q, last_p2_q, last_p3_q;
  logic [CW-1:0] a0_p1_q, a1_p1_q;
  logic [PW-1:0] m00_d, m01_d, m10_d, m11_d;
  logic [PW-1:0] m00_p2_q, m01_p2_q, m10_p2_q, m11_p2_q;
  logic [SW-1:0] s0r, s0i, s1r, s1i;
  logic [CW-1:0] b0_p3_d, b1_p3_d, b0_p3_q, b1_p3_q;
  logic          sat_p3_d;
  logic          sat_flag_q;
  logic [CW-1:0] coef_q [4];

  assign en       = !vld_p3_q || out_ready;
  assign accept   = in_valid && en;
  assign busy     = vld_p1_q || vld_p2_q || vld_p3_q;
  assign wr_ok    = gate_we && !busy && !accept;
  assign in_ready = en;

  complex_fix_mul #(.IN_BITS(IN_BITS), .PROD_BITS(PROD_BITS)) u_m00 (
    .a_i(coef_q[0]), .b_i(a0_p1_q), .p_o(m00_d));
  complex_fix_mul #(.IN_BITS(IN_BITS), .PROD_BITS(PROD_BITS)) u_m01 (
    .a_i(coef_q[1]), .b_i(a1_p1_q), .p_o(m01_d));
  complex_fix_mul #(.IN_BITS(IN_BITS), .PROD_BITS(PROD_BITS)) u_m10 (
    .a_i(coef_q[2]), .b_i(a0_p1_q), .p_o(m10_d));
  complex_fix_mul #(.IN_BITS(IN_BITS), .PROD_BITS(PROD_BITS)) u_m11 (
    .a_i(coef_q[3]), .b_i(a1_p1_q), .p_o(m11_d));

  assign s0r = add_ext(m00_p2_q[PROD_BITS-1:0],  m01_p2_q[PROD_BITS-1:0]);
  assign s0i = add_ext(m00_p2_q[PW-1:PROD_BITS], m01_p2_q[PW-1:PROD_BITS]);
  assign s1r = add_ext(m10_p2_q[PROD_BITS-1:0],  m11_p2_q[PROD_BITS-1:0]);
  assign s1i = add_ext(m10_p2_q[PW-1:PROD_BITS], m11_p2_q[PW-1:PROD_BITS]);

  always_comb begin
    b0_p3_d  = {sat_sum(s0i), sat_sum(s0r)};
    b1_p3_d  = {sat_sum(s1i), sat_sum(s1r)};
    sat_p3_d = sum_ovf(s0r) || sum_ovf(s0i) || sum_ovf(s1r) || sum_ovf(s1i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      last_p1_q <= 1'b0;
      last_p2_q <= 1'b0;
      last_p3_q <= 1'b0;
      a0_p1_q   <= '0;
      a1_p1_q   <= '0;
      m00_p2_q  <= '0;
      m01_p2_q  <= '0;
      m10_p2_q  <= '0;
      m11_p2_q  <= '0;
      b0_p3_q   <= '0;
      b1_p3_q   <= '0;
    end else if (en) begin
      // S1: accepted amplitude pair
      vld_p1_q  <= in_valid;
      last_p1_q <= in_valid && in_last;
      a0_p1_q   <= in_a0;
      a1_p1_q   <= in_a1;
      // S2: four complex products
      vld_p2_q  <= vld_p1_q;
      last_p2_q <= last_p1_q;
      m00_p2_q  <= m00_d;
      m01_p2_q  <= m01_d;
      m10_p2_q  <= m10_d;
      m11_p2_q  <= m11_d;
      // S3: saturated sums, drive the output port
      vld_p3_q  <= vld_p2_q;
      last_p3_q <= last_p2_q;
      b0_p3_q   <= b0_p3_d;
      b1_p3_q   <= b1_p3_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coef_q[0] <= ONE;
      coef_q[1] <= '0;
      coef_q[2] <= '0;
      coef_q[3] <= ONE;
    end else if (wr_ok) begin
      coef_q[gate_sel] <= gate_coef;
    end
  end

  // A gate write only lands when idle, so it never races a saturating S3 load.
  always_ff @(posedge clk) begin
    if (rst || wr_ok)
      sat_flag_q <= 1'b0;
    else if (en && vld_p2_q && sat_p3_d)
      sat_flag_q <= 1'b1;
  end

  assign out_valid = vld_p3_q;
  assign out_last  = last_p3_q;
  assign out_b0    = b0_p3_q;
  assign out_b1    = b1_p3_q;
  assign sat_flag  = sat_flag_q;
endmodule

// File: tb/tb_gate_pair_apply.sv
// Bench for gate_pair_apply: directed vector table, hand-written corner
// sequences and randomized traffic scored against an arithmetic model.

module tb_gate_pair_apply;
  localparam int N  = 19;
  localparam int CW = 2*N;
  localparam longint ONE = 131072;

  logic          clk = 1'b0;
  logic          rst, gate_we, busy, in_valid, in_ready, in_last;
  logic          out_valid, out_ready, out_last, sat_flag;
  logic [1:0]    gate_sel;
  logic [CW-1:0] gate_coef, in_a0, in_a1, out_b0, out_b1;

  gate_pair_apply #(.IN_BITS(N), .PROD_BITS(N+1)) dut (
    .clk(clk), .rst(rst), .gate_we(gate_we), .gate_sel(gate_sel),
    .gate_coef(gate_coef), .busy(busy), .in_valid(in_valid),
    .in_ready(in_ready), .in_a0(in_a0), .in_a1(in_a1), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_b0(out_b0),
    .out_b1(out_b1), .out_last(out_last), .sat_flag(sat_flag));

  always #5 clk = ~clk;

  typedef struct {
    longint b0r, b0i, b1r, b1i;
    bit     last;
    bit     sat;
    int     cyc;
  } exp_t;

  typedef struct {
    bit                     load;
    logic [7:0][N-1:0]      u;
    longint                 a0r, a0i, a1r, a1i;
    longint                 e0r, e0i, e1r, e1i;
    bit                     esat;
    int                     tol;
  } vec_t;

  int     total = 0, bad = 0;
  int     cyc = 0, in_xfers = 0, out_cnt = 0;
  bit     lat_chk = 0, msat = 0, done = 0;
  longint mcr [4], mci [4];
  longint lb0r, lb0i, lb1r, lb1i;
  exp_t   q [$];
  int     oc [$];
  vec_t   vt [7];

  task automatic chk(input string name, input longint act, input longint req, input int tol = 0);
    longint d;
    total++;
    d = act - req;
    if (d < 0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d) at cycle %0d", name, act, req, tol, cyc);
    end
  endtask

  function automatic logic [CW-1:0] pk(input longint r, input longint i);
    logic [CW-1:0] v;
    v[N-1:0]  = r[N-1:0];
    v[CW-1:N] = i[N-1:0];
    return v;
  endfunction

  function automatic longint s19(input logic [N-1:0] x);
    logic signed [N-1:0] t;
    t = x;
    return longint'(t);
  endfunction

  function automatic longint cre(input logic [CW-1:0] v); return s19(v[N-1:0]); endfunction
  function automatic longint cim(input logic [CW-1:0] v); return s19(v[CW-1:N]); endfunction

  function automatic longint clampv(input longint v, input int bits, inout bit s);
    longint lim;
    lim = longint'(1) << (bits - 1);
    if (v > lim - 1) begin s = 1; return lim - 1; end
    if (v < -lim) begin s = 1; return -lim; end
    return v;
  endfunction

  // Reference: b = U*a with exact products floored to Q2, then clamped sums.
  function automatic exp_t model(input longint a0r, a0i, a1r, a1i, input bit last);
    exp_t   e;
    longint ar [4], ai [4], pr [4], pi [4];
    bit     pdummy, s;
    ar = '{a0r, a1r, a0r, a1r};
    ai = '{a0i, a1i, a0i, a1i};
    pdummy = 0;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      pr[k] = clampv((mcr[k]*ar[k] - mci[k]*ai[k]) >>> (N-2), N+1, pdummy);
      pi[k] = clampv((mcr[k]*ai[k] + mci[k]*ar[k]) >>> (N-2), N+1, pdummy);
    end
    e.b0r  = clampv(pr[0] + pr[1], N, s);
    e.b0i  = clampv(pi[0] + pi[1], N, s);
    e.b1r  = clampv(pr[2] + pr[3], N, s);
    e.b1i  = clampv(pi[2] + pi[3], N, s);
    e.sat  = s;
    e.last = last;
    e.cyc  = 0;
    return e;
  endfunction

  function automatic vec_t mkv(input bit load,
      input longint u00r, u00i, u01r, u01i, u10r, u10i, u11r, u11i,
      input longint a0r, a0i, a1r, a1i, e0r, e0i, e1r, e1i,
      input bit esat, input int tol);
    vec_t v;
    longint uu [8];
    uu = '{u00r, u00i, u01r, u01i, u10r, u10i, u11r, u11i};
    for (int k = 0; k < 8; k++) v.u[k] = uu[k][N-1:0];
    v.load = load;
    v.a0r = a0r; v.a0i = a0i; v.a1r = a1r; v.a1i = a1i;
    v.e0r = e0r; v.e0i = e0i; v.e1r = e1r; v.e1i = e1i;
    v.esat = esat; v.tol = tol;
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: transfers are decided on the falling edge, before the next rise.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      q.delete();
      msat = 0;
    end else begin
      if (in_valid && in_ready) begin
        exp_t e;
        e = model(cre(in_a0), cim(in_a0), cre(in_a1), cim(in_a1), in_last);
        e.cyc = cyc;
        q.push_back(e);
        in_xfers++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          msat = msat | e.sat;
          chk("sb_b0r", cre(out_b0), e.b0r);
          chk("sb_b0i", cim(out_b0), e.b0i);
          chk("sb_b1r", cre(out_b1), e.b1r);
          chk("sb_b1i", cim(out_b1), e.b1i);
          chk("sb_last", longint'(out_last), longint'(e.last));
          chk("sb_sat", longint'(sat_flag), longint'(msat));
          if (lat_chk) chk("latency", cyc - e.cyc, 3);
        end
        lb0r = cre(out_b0); lb0i = cim(out_b0);
        lb1r = cre(out_b1); lb1i = cim(out_b1);
        oc.push_back(cyc);
        out_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic identity_model();
    mcr = '{ONE, 0, 0, ONE};
    mci = '{0, 0, 0, 0};
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; gate_we = 0; out_ready = 1;
    @(posedge clk); #1;
    rst = 0;
    identity_model();
  endtask

  task automatic write_coef(input int k, input longint r, input longint i);
    int t = 0;
    while (busy && t < 100) begin @(posedge clk); #1; t++; end
    if (busy) chk("wait_idle", 1, 0);
    in_valid = 0;
    gate_we = 1; gate_sel = k[1:0]; gate_coef = pk(r, i);
    @(posedge clk); #1;
    gate_we = 0;
    mcr[k] = r; mci[k] = i;
    msat = 0;
  endtask

  task automatic send(input longint a0r, a0i, a1r, a1i, input bit last);
    int start = in_xfers;
    int t = 0;
    in_valid = 1; in_a0 = pk(a0r, a0i); in_a1 = pk(a1r, a1i); in_last = last;
    while (in_xfers == start && t < 60) begin @(posedge clk); #1; t++; end
    if (in_xfers == start) chk("send_timeout", 0, 1);
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_out(input int start);
    int t = 0;
    while (out_cnt == start && t < 30) begin @(posedge clk); #1; t++; end
    chk("out_arrived", out_cnt - start, 1);
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1;
    while ((busy || q.size() != 0) && t < 100) begin @(posedge clk); #1; t++; end
    chk("drain_q", q.size(), 0);
  endtask

  function automatic longint rnd1();
    return longint'($urandom_range(0, 262144)) - ONE;
  endfunction

  initial begin
    int base, st;
    longint cap;
    rst = 1; gate_we = 0; gate_sel = 0; gate_coef = '0; in_valid = 0;
    in_a0 = '0; in_a1 = '0; in_last = 0; out_ready = 1;
    identity_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_sat", longint'(sat_flag), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_last", longint'(out_last), 0);
    chk("rst_out_b0", longint'(out_b0), 0);

    vt[0] = mkv(0, ONE,0, 0,0, 0,0, ONE,0,  65536,-32768, 0,131072,
                65536,-32768, 0,131072, 0, 0);
    vt[1] = mkv(1, 0,0, ONE,0, ONE,0, 0,0,  1000,-2000, 3000,4000,
                3000,4000, 1000,-2000, 0, 0);
    vt[2] = mkv(1, 92682,0, 92682,0, 92682,0, -92682,0,  ONE,0, 0,0,
                92682,0, 92682,0, 0, 1);
    vt[3] = mkv(1, ONE,0, ONE,0, 0,0, 0,0,  196608,-196608, 196608,-196608,
                262143,-262144, 0,0, 1, 0);
    vt[4] = mkv(1, 0,ONE, 65536,0, 65536,65536, -ONE,0,  40000,20000, -8000,12000,
                -24000,46000, 18000,18000, 0, 0);
    vt[5] = mkv(1, 1,0, 0,0, 0,0, 0,0,  131071,-131071, 5,5,
                0,-1, 0,0, 0, 0);
    vt[6] = mkv(1, 0,0, 0,0, -ONE,0, -ONE,0,  -196608,100000, -196608,100000,
                0,0, 262143,-200000, 1, 0);

    lat_chk = 1;
    foreach (vt[i]) begin
      if (vt[i].load) begin
        for (int k = 0; k < 4; k++)
          write_coef(k, s19(vt[i].u[2*k]), s19(vt[i].u[2*k+1]));
        chk($sformatf("v%0d_sat_clr", i), longint'(sat_flag), 0);
      end
      st = out_cnt;
      send(vt[i].a0r, vt[i].a0i, vt[i].a1r, vt[i].a1i, 0);
      wait_out(st);
      chk($sformatf("v%0d_b0r", i), lb0r, vt[i].e0r, vt[i].tol);
      chk($sformatf("v%0d_b0i", i), lb0i, vt[i].e0i, vt[i].tol);
      chk($sformatf("v%0d_b1r", i), lb1r, vt[i].e1r, vt[i].tol);
      chk($sformatf("v%0d_b1i", i), lb1i, vt[i].e1i, vt[i].tol);
      chk($sformatf("v%0d_sat", i), longint'(sat_flag), longint'(vt[i].esat));
    end
    drain();

    // Pauli-X burst: 8 back-to-back pairs, last tag only on the eighth
    write_coef(0, 0, 0);   write_coef(1, ONE, 0);
    write_coef(2, ONE, 0); write_coef(3, 0, 0);
    base = oc.size();
    for (int i = 0; i < 8; i++)
      send(rnd1(), rnd1(), rnd1(), rnd1(), i == 7);
    drain();
    chk("x_count", oc.size() - base, 8);
    if (oc.size() - base == 8) chk("x_back_to_back", oc[base+7] - oc[base], 7);
    lat_chk = 0;

    // Backpressure: stall 5 cycles once the first result is presented
    base = out_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) send(rnd1(), rnd1(), rnd1(), rnd1(), i == 3);
      end
      begin
        int t = 0;
        while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
        chk("bp_seen", longint'(out_valid), 1);
        out_ready = 0;
        cap = longint'(out_b0);
        for (int i = 0; i < 5; i++) begin
          #2;
          chk("bp_in_ready", longint'(in_ready), 0);
          chk("bp_valid_hold", longint'(out_valid), 1);
          chk("bp_b0_stable", longint'(out_b0), cap);
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    drain();
    chk("bp_count", out_cnt - base, 4);

    // Write attempted while busy must be ignored (Pauli-X still loaded)
    send(1000, 2000, 3000, 4000, 0);
    chk("wb_busy", longint'(busy), 1);
    gate_we = 1; gate_sel = 2'd0; gate_coef = pk(ONE, 0);
    @(posedge clk); #1;
    gate_we = 0;
    drain();
    st = out_cnt;
    send(5000, -6000, 7000, 8000, 0);
    wait_out(st);
    chk("wb_b0r", lb0r, 7000);
    chk("wb_b0i", lb0i, 8000);
    drain();

    // Randomized traffic with random coefficients, gaps and stalls
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) write_coef(k, rnd1(), rnd1());
      done = 0;
      fork
        begin
          for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send(rnd1(), rnd1(), rnd1(), rnd1(), $urandom_range(0, 7) == 0);
          end
          done = 1;
        end
        begin
          while (!done) begin
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
          end
          out_ready = 1;
        end
      join
      drain();
    end

    // Reset with two pairs in flight under a non-identity gate
    write_coef(0, 0, ONE);
    send(11111, 2222, 3333, 4444, 0);
    send(5555, 6666, 7777, 8888, 1);
    chk("rm_busy_before", longint'(busy), 1);
    base = out_cnt;
    do_reset();
    chk("rm_out_valid", longint'(out_valid), 0);
    chk("rm_busy", longint'(busy), 0);
    chk("rm_sat", longint'(sat_flag), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("rm_no_output", out_cnt - base, 0);
    st = out_cnt;
    send(12345, -23456, -34567, 45678, 0);
    wait_out(st);
    chk("rm_ident_b0r", lb0r, 12345);
    chk("rm_ident_b0i", lb0i, -23456);
    chk("rm_ident_b1r", lb1r, -34567);
    chk("rm_ident_b1i", lb1i, 45678);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gate_pair_apply.md
Name: gate_pair_apply

Overview:
- Streaming 2x2 complex gate application stage. Consumes amplitude pairs (a0, a1) from the state-vector fetch stage.
- Produces out0 = u00*a0 + u01*a1 and out1 = u10*a0 + u11*a1 for the state-vector writeback stage.
- Built around four complex_fix_mul instances plus a registered valid/ready pipeline, a gate-coefficient register file and saturating accumulation.
- Throughput is one pair per cycle.

Parameters:
- IN_BITS, 19: width of each real/imag component of amplitudes, coefficients and outputs. Signed fixed point Q2.(IN_BITS-2), so 1.0 = 2^(IN_BITS-2).
- PROD_BITS, IN_BITS+1: output width of each complex_fix_mul. Same scaling as the inputs.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- gate_we  in  1  coefficient write strobe
- gate_sel  in  2  coefficient index: 0=u00, 1=u01, 2=u10, 3=u11
- gate_coef  in  2x IN_BITS  coefficient; [0] real, [1] imag
- busy  out  1  high while any pipeline stage holds valid data
- in_valid  in  1  input pair valid
- in_ready  out  1  stage can accept a pair this cycle
- in_a0  in  2x IN_BITS  amplitude 0; [0] real, [1] imag
- in_a1  in  2x IN_BITS  amplitude 1
- in_last  in  1  marks final pair of a gate pass; passed through
- out_valid  out  1  output pair valid
- out_ready  in  1  downstream accepts
- out_b0  out  2x IN_BITS  result amplitude 0
- out_b1  out  2x IN_BITS  result amplitude 1
- out_last  out  1  in_last delayed with its pair
- sat_flag  out  1  sticky: any component saturated since reset or last gate write

Behaviour:
- Reset (rst high at a clk edge):
  - All stage valid bits, out_valid, out_last, sat_flag and busy clear to 0.
  - Data registers clear to 0.
  - Coefficient file resets to identity: u00 = u11 = 1.0+0i, u01 = u10 = 0.
  - Reset mid-stream discards all in-flight pairs; no output is emitted for them.
- Pipeline: three stages, all advancing on a single enable en = !out_valid || out_ready.
  - S1 registers the accepted inputs.
  - S2 registers the four complex products: u00*a0, u01*a1, u10*a0, u11*a1.
  - S3 registers the saturated sums and drives out_*.
- Handshake:
  - in_ready = en. A pair transfers when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - While out_valid && !out_ready, all stages hold and out_* are stable.
  - Bubbles propagate: a stage whose upstream is empty loads valid = 0 when en is high.
- Latency: 3 clk edges from input transfer to out_valid, with out_ready held high. Back-to-back pairs produce back-to-back outputs.
- Arithmetic:
  - Complex product imag = bc + ad (re*im + im*re); real = ac - bd.
  - Each sum is formed per component in PROD_BITS+1 bits by sign-extending both products.
  - Result saturates to IN_BITS: max 2^(IN_BITS-1)-1, min -2^(IN_BITS-1).
  - Truncation only, no rounding.
  - Any saturating component sets sat_flag in the cycle its S3 register loads.
- Coefficient writes:
  - Accepted only when !busy && !(in_valid && in_ready) in that cycle. Otherwise ignored entirely; the writer must wait for !busy.
  - An accepted write updates the indexed coefficient at the edge and clears sat_flag.
  - The new value applies to the next pair accepted.
- busy = OR of S1/S2/S3 valid bits.
- out_last follows its pair exactly. No internal state depends on last; it is purely a pass-through tag.

Test Plan:
- Reset then identity gate: a0 = (65536, -32768), a1 = (0, 131072) -> after 3 cycles out_b0 = (65536, -32768), out_b1 = (0, 131072); sat_flag = 0.
- Load Pauli-X (u00 = u11 = 0, u01 = u10 = 131072): stream 8 consecutive pairs -> outputs swapped, 8 consecutive out_valid cycles, in_last on pair 8 appears on output 8 only.
- Hadamard (u00 = u01 = u10 = 92682, u11 = -92682): a0 = (131072, 0), a1 = 0 -> out_b0 = out_b1 = (92682, 0) within 1 LSB.
- Saturation: u00 = u01 = 131072, a0 = a1 = (196608, -196608) -> out_b0 = (262143, -262144), sat_flag = 1. A subsequent gate write clears sat_flag.
- Backpressure: stream 4 pairs, hold out_ready low 5 cycles after first out_valid -> in_ready low, out_b0 stable, no pair lost or duplicated, order preserved.
- Write while busy: gate_we asserted while busy = 1 -> coefficient unchanged.
- Reset mid-stream: assert rst with 2 pairs in flight -> next cycle out_valid = 0, busy = 0, coefficients back to identity.
